line_steer_ctrl: RTL and testbench

LINE_STEER_CTRL -- requirements
Module: line_steer_ctrl

---
 rtl/line_steer_if.sv | 26 ++
 rtl/line_steer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/line_steer_if.sv
// line_steer_if: bus bundle for line_steer_ctrl.
// Ports (slave view): tick, en, DI, DL, DD in; duty_l[3:0], duty_r[3:0],
// m1d, m1r, m2d, m2r, state[2:0], lost out. The master view is the mirror.
interface line_steer_if;
    logic       tick;
    logic       en;
    logic       DI;
    logic       DL;
    logic       DD;
    logic [3:0] duty_l;
    logic [3:0] duty_r;
    logic       m1d;
    logic       m1r;
    logic       m2d;
    logic       m2r;
    logic [2:0] state;
    logic       lost;
    modport slave (
        input  tick, en, DI, DL, DD,
        output duty_l, duty_r, m1d, m1r, m2d, m2r, state, lost
    );
    modport master (
        output tick, en, DI, DL, DD,
        input  duty_l, duty_r, m1d, m1r, m2d, m2r, state, lost
    );
endinterface

// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl: line-follower steering FSM with debounced sensors and motor decode.
// Ports: clk, rst_n (sync, active-low); bus (line_steer_if.slave):
//   tick, en, DI/DL/DD in; duty_l, duty_r, m1d/m1r, m2d/m2r, state, lost out.
// Optional search behaviour enabled by macro LINE_STEER_SEARCH_EN.
module line_steer_ctrl #(
    parameter int unsigned DEB_TICKS  = 4,
    parameter int unsigned LOST_TICKS = 64,
    parameter int unsigned STOP_TICKS = 255,
    parameter logic [3:0]  DUTY_FWD   = 4'd13,
    parameter logic [3:0]  DUTY_TURN  = 4'd6,
    parameter logic [3:0]  DUTY_PIVOT = 4'd9
) (
    input  logic         clk,
    input  logic         rst_n,
    line_steer_if.slave  bus
);
    typedef enum logic [2:0] {
        STOP   = 3'd0,
        FWD    = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3
`ifdef LINE_STEER_SEARCH_EN
        ,
        SEARCH_L = 3'd4,
        SEARCH_R = 3'd5
`endif
    } state_t;

    logic [2:0] sync1, sync2;
    logic [2:0] cand, cand_d, acc, acc_d;
    logic [3:0] cnt, cnt_d;
    state_t     state_q, state_d;
    logic       side, side_d;

`ifdef LINE_STEER_SEARCH_EN
    logic [7:0] lcnt, lcnt_d, scnt, scnt_d;
    logic       lost_q, lost_d;
    logic       in_search;
`endif

    // Debounce: the accepted pattern is updated on the same tick the candidate
    // completes its hold, so the FSM steers from the freshly accepted value.
    always_comb begin
        cand_d = cand;
        cnt_d  = cnt;
        acc_d  = acc;
        if (bus.tick) begin
            if (sync2 != cand) begin
                cand_d = sync2;
                cnt_d  = 4'd0;
            end else if (cnt != 4'hf) begin
                cnt_d = cnt + 4'd1;
            end
            if (cnt_d == 4'(DEB_TICKS - 1))
                acc_d = cand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        side_d  = side;
`ifdef LINE_STEER_SEARCH_EN
        lcnt_d    = lcnt;
        scnt_d    = scnt;
        lost_d    = lost_q;
        in_search = (state_q == SEARCH_L) || (state_q == SEARCH_R);
`endif
        if (!bus.en) begin
            state_d = STOP;
`ifdef LINE_STEER_SEARCH_EN
            lcnt_d = 8'd0;
            scnt_d = 8'd0;
            lost_d = 1'b0;
`endif
        end else if (bus.tick) begin
            case (acc_d)
                3'b010, 3'b111: state_d = FWD;
                3'b110, 3'b100: state_d = TURN_L;
                3'b011, 3'b001: state_d = TURN_R;
                default:        state_d = state_q;
            endcase
`ifdef LINE_STEER_SEARCH_EN
            lcnt_d = (acc_d != 3'b000) ? 8'd0 : (lcnt == 8'hff) ? lcnt : lcnt + 8'd1;
            scnt_d = (in_search && acc_d == 3'b000) ? ((scnt == 8'hff) ? scnt : scnt + 8'd1) : 8'd0;
            // Search is only entered from a running state; STOP keeps waiting on 000.
            if (acc_d == 3'b000) begin
                if (in_search && scnt_d >= 8'(STOP_TICKS))
                    state_d = STOP;
                else if (state_q inside {FWD, TURN_L, TURN_R} && lcnt_d >= 8'(LOST_TICKS))
                    state_d = side ? SEARCH_R : SEARCH_L;
            end
            // lost survives into STOP only when that STOP came from a search timeout.
            lost_d = (state_d == SEARCH_L) || (state_d == SEARCH_R) || (lost_q && state_d == STOP);
`endif
            side_d = (state_d == TURN_L) ? 1'b0 : (state_d == TURN_R) ? 1'b1 : side;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 3'b000;
            sync2   <= 3'b000;
            cand    <= 3'b000;
            cnt     <= 4'd0;
            acc     <= 3'b000;
            state_q <= STOP;
            side    <= 1'b0;
        end else begin
            sync1   <= {bus.DI, bus.DL, bus.DD};
            sync2   <= sync1;
            cand    <= cand_d;
            cnt     <= cnt_d;
            acc     <= acc_d;
            state_q <= state_d;
            side    <= side_d;
        end
    end

`ifdef LINE_STEER_SEARCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt   <= 8'd0;
            scnt   <= 8'd0;
            lost_q <= 1'b0;
        end else begin
            lcnt   <= lcnt_d;
            scnt   <= scnt_d;
            lost_q <= lost_d;
        end
    end
    assign bus.lost = lost_q;
`else
    assign bus.lost = 1'b0;
`endif

    assign bus.state = state_q;

    // Each state drives at most one direction bit per motor.
    always_comb begin
        bus.duty_l = 4'd0;
        bus.duty_r = 4'd0;
        bus.m1d    = 1'b0;
        bus.m1r    = 1'b0;
        bus.m2d    = 1'b0;
        bus.m2r    = 1'b0;
        case (state_q)
            FWD: begin
                bus.duty_l = DUTY_FWD;
                bus.duty_r = DUTY_FWD;
                bus.m1d    = 1'b1;
                bus.m2d    = 1'b1;
            end
            TURN_L: begin
                bus.duty_l = DUTY_TURN;
                bus.duty_r = DUTY_FWD;
                bus.m1d    = 1'b1;
                bus.m2d    = 1'b1;
            end
            TURN_R: begin
                bus.duty_l = DUTY_FWD;
                bus.duty_r = DUTY_TURN;
                bus.m1d    = 1'b1;
                bus.m2d    = 1'b1;
            end
`ifdef LINE_STEER_SEARCH_EN
            SEARCH_L: begin
                bus.duty_l = DUTY_PIVOT;
                bus.duty_r = DUTY_PIVOT;
                bus.m1r    = 1'b1;
                bus.m2d    = 1'b1;
            end
            SEARCH_R: begin
                bus.duty_l = DUTY_PIVOT;
                bus.duty_r = DUTY_PIVOT;
                bus.m1d    = 1'b1;
                bus.m2r    = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_steer_ctrl.sv
// tb_line_steer_ctrl: directed self-checking bench for line_steer_ctrl.
// Ports: none; drives clk, rst_n and a line_steer_if instance.
module tb_line_steer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    line_steer_if bus();

    line_steer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    // Packed as {state, duty_l, duty_r, m1d, m1r, m2d, m2r, lost}.
    task automatic expect_out(input string tag, input int st, input int dl, input int dr,
                              input logic [3:0] dir, input logic lo);
        chk(tag, {bus.state, bus.duty_l, bus.duty_r, bus.m1d, bus.m1r, bus.m2d, bus.m2r, bus.lost},
            {3'(st), 4'(dl), 4'(dr), dir, lo});
    endtask

    task automatic excl();
        checks++;
        assert (!(bus.m1d && bus.m1r) && !(bus.m2d && bus.m2r)) else begin
            failures++;
            $error("FAIL dir_excl observed=%b%b%b%b expected=no_fwd_rev_pair",
                   bus.m1d, bus.m1r, bus.m2d, bus.m2r);
        end
    endtask

    // One tick every 8 clocks; returns 1.5 clocks after the tick edge.
    task automatic ticks(input int n);
        repeat (n) begin
            repeat (6) begin
                @(negedge clk);
                excl();
            end
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            @(negedge clk);
            excl();
        end
    endtask

    task automatic set_pat(input logic [2:0] p);
        {bus.DI, bus.DL, bus.DD} = p;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.en   = 1'b0;
        set_pat(3'b000);
        repeat (3) @(negedge clk);
        expect_out("reset", 0, 0, 0, 4'b0000, 1'b0);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        set_pat(3'b010);
        ticks(3);
        expect_out("deb_3_ticks", 0, 0, 0, 4'b0000, 1'b0);
        ticks(1);
        expect_out("fwd", 1, 13, 13, 4'b1010, 1'b0);
        set_pat(3'b110);
        ticks(2);
        set_pat(3'b010);
        ticks(4);
        expect_out("glitch_reject", 1, 13, 13, 4'b1010, 1'b0);
        set_pat(3'b110);
        ticks(3);
        expect_out("turn_l_3_ticks", 1, 13, 13, 4'b1010, 1'b0);
        ticks(1);
        expect_out("turn_l", 2, 6, 13, 4'b1010, 1'b0);
        set_pat(3'b000);
`ifdef LINE_STEER_SEARCH_EN
        ticks(3 + 63);
        expect_out("lost_63", 2, 6, 13, 4'b1010, 1'b0);
        ticks(1);
        expect_out("search_l", 4, 9, 9, 4'b0110, 1'b1);
        ticks(254);
        expect_out("search_254", 4, 9, 9, 4'b0110, 1'b1);
        ticks(1);
        expect_out("search_timeout", 0, 0, 0, 4'b0000, 1'b1);
        ticks(5);
        expect_out("stop_holds_000", 0, 0, 0, 4'b0000, 1'b1);
        set_pat(3'b001);
        ticks(4);
        expect_out("turn_r_from_stop", 3, 13, 6, 4'b1010, 1'b0);
        set_pat(3'b000);
        ticks(3 + 64);
        expect_out("search_r", 5, 9, 9, 4'b1001, 1'b1);
        set_pat(3'b001);
        ticks(3);
        expect_out("search_r_deb", 5, 9, 9, 4'b1001, 1'b1);
        ticks(1);
        expect_out("search_r_exit", 3, 13, 6, 4'b1010, 1'b0);
`else
        ticks(100);
        expect_out("hold_000", 2, 6, 13, 4'b1010, 1'b0);
        set_pat(3'b001);
        ticks(4);
        expect_out("turn_r", 3, 13, 6, 4'b1010, 1'b0);
`endif
        bus.en   = 1'b0;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.en   = 1'b1;
        bus.tick = 1'b0;
        expect_out("en_low_stop", 0, 0, 0, 4'b0000, 1'b0);
        ticks(1);
        expect_out("en_resume", 3, 13, 6, 4'b1010, 1'b0);
        set_pat(3'b100);
        ticks(4);
        expect_out("turn_l_again", 2, 6, 13, 4'b1010, 1'b0);
        set_pat(3'b000);
`ifdef LINE_STEER_SEARCH_EN
        ticks(3 + 64 + 10);
        expect_out("search_l_again", 4, 9, 9, 4'b0110, 1'b1);
`else
        ticks(10);
        expect_out("hold_000_again", 2, 6, 13, 4'b1010, 1'b0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("mid_reset", 0, 0, 0, 4'b0000, 1'b0);
        set_pat(3'b010);
        ticks(3);
        expect_out("post_reset_deb", 0, 0, 0, 4'b0000, 1'b0);
        ticks(1);
        expect_out("post_reset_fwd", 1, 13, 13, 4'b1010, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
